gate_bist_checker: RTL and testbench

GATE_BIST_CHECKER -- requirements
Module: gate_bist_checker

---
 rtl/gate_bist_pkg.sv | 40 ++++
 rtl/gate_bist_compare.sv | 26 ++
 rtl/gate_bist_checker.sv | 112 +++++++++++
 tb/tb_gate_bist_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared definitions for the two-input gate BIST checker: FSM states, golden
// truth table, response bit positions and the error ceiling.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int RESP_W    = 7;
  localparam int RESP_NOT  = 6;
  localparam int RESP_NAND = 5;
  localparam int RESP_NOR  = 4;
  localparam int RESP_AND  = 3;
  localparam int RESP_OR   = 2;
  localparam int RESP_XOR  = 1;
  localparam int RESP_XNOR = 0;

  localparam logic [4:0] ERR_MAX = 5'd28;

  // Indexed by vector {a,b}; bit positions follow the RESP_* constants.
  localparam logic [3:0][RESP_W-1:0] GOLDEN = {
    7'b0001101,
    7'b0100110,
    7'b1100110,
    7'b1110001
  };

  function automatic logic [2:0] popcount7(input logic [RESP_W-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int j = 0; j < RESP_W; j++) begin
      c = c + {2'b00, v[j]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gate_bist_compare.sv
// Combinational check of one response word against the golden entry for
// the current vector; yields the mismatch mask and its bit count.
module gate_bist_compare
  import gate_bist_pkg::*;
(
  input  logic [1:0]        vec,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] mask,
  output logic [2:0]        errs
);

  logic [RESP_W-1:0] golden;

  assign golden = GOLDEN[vec];

  // Case equality so a floating or unknown response never passes as a match.
  always_comb begin
    mask = '0;
    for (int j = 0; j < RESP_W; j++) begin
      mask[j] = (resp[j] === golden[j]) ? 1'b0 : 1'b1;
    end
  end

  assign errs = popcount7(mask);

endmodule

// File: rtl/gate_bist_checker.sv
// Truth-table BIST for the NOT/NAND/NOR/AND/OR/XOR/XNOR gate set: walks the
// four input vectors, lets each settle, samples responses and logs errors.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              a_drv,
  output logic              b_drv,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic [3:0]        fail_vec,
  output logic [RESP_W-1:0] fail_gate
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        settle_cnt;
  logic [1:0]        vec;
  logic [RESP_W-1:0] mismatch;
  logic [2:0]        mismatch_cnt;
  logic              accept;
  logic              sample_en;

  function automatic logic [4:0] sat_add(input logic [4:0] acc, input logic [2:0] inc);
    logic [5:0] sum;
    sum = {1'b0, acc} + {3'b000, inc};
    return (sum > {1'b0, ERR_MAX}) ? ERR_MAX : sum[4:0];
  endfunction

  gate_bist_compare u_compare (
    .vec  (vec),
    .resp (resp),
    .mask (mismatch),
    .errs (mismatch_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (vec == 2'b11) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (start) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Start is only honoured from IDLE/DONE, which is what makes it inert mid-run.
  always_comb begin
    accept    = 1'b0;
    sample_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:   accept = start;
      ST_SETTLE: busy = 1'b1;
      ST_SAMPLE: begin
        busy      = 1'b1;
        sample_en = 1'b1;
      end
      ST_DONE: begin
        done   = 1'b1;
        accept = start;
      end
      default: ;
    endcase
    pass = done && (err_count == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      settle_cnt <= '0;
      vec        <= '0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_gate  <= '0;
    end else if (state == ST_SETTLE) begin
      if (settle_cnt != SETTLE_LAST) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end else if (sample_en) begin
      err_count  <= sat_add(err_count, mismatch_cnt);
      fail_vec   <= fail_vec | ({3'b000, |mismatch} << vec);
      fail_gate  <= fail_gate | mismatch;
      settle_cnt <= '0;
      if (vec != 2'b11) begin
        vec <= vec + 2'd1;
      end
    end
  end

  assign a_drv = vec[1];
  assign b_drv = vec[0];

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: two instances (settle 4 and settle 1) driven by
// fault-injecting gate models, checked every cycle against a timing model.
module tb_gate_bist_checker;

  localparam int SC0 = 4;
  localparam int SC1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      start;
  logic [1:0]      a_drv;
  logic [1:0]      b_drv;
  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0]      pass;
  logic [1:0][4:0] err_count;
  logic [1:0][3:0] fail_vec;
  logic [1:0][6:0] fail_gate;
  logic [1:0][6:0] resp;

  int   mode [2];
  int   md   [2];
  int   n_m  [2];
  logic unk;
  logic four_state;
  bit   cmp_en;
  int   checks;
  int   errors;

  function automatic int sc_of(input int i);
    return (i == 0) ? SC0 : SC1;
  endfunction

  // Fault-free behaviour of the gate set for inputs a, b.
  function automatic logic [6:0] ideal(input logic a, input logic b);
    return {~a, ~(a & b), ~(a | b), a & b, a | b, a ^ b, ~(a ^ b)};
  endfunction

  // 1: AND stuck-at-0, 2: XOR/XNOR swapped, 3: NOR output unknown,
  // 4: OR stuck-at-1, 5: every output inverted.
  function automatic logic [6:0] drive_resp(input logic a, input logic b, input int m,
                                            input logic fs, input logic u);
    logic [6:0] r;
    r = ideal(a, b);
    case (m)
      1: r[3] = 1'b0;
      2: r[1:0] = {r[0], r[1]};
      3: r[4] = fs ? u : ~r[4];
      4: r[2] = 1'b1;
      5: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] vec_mask(input int v, input int m);
    logic [1:0] vv;
    logic [6:0] good;
    logic [6:0] got;
    logic [6:0] mk;
    vv   = v[1:0];
    good = ideal(vv[1], vv[0]);
    got  = drive_resp(vv[1], vv[0], m, four_state, unk);
    mk   = '0;
    for (int j = 0; j < 7; j++) begin
      if (got[j] !== good[j]) mk[j] = 1'b1;
    end
    return mk;
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      gate_bist_checker #(.SETTLE_CYCLES(g == 0 ? SC0 : SC1)) dut (
        .clk       (clk),
        .rst       (rst[g]),
        .start     (start[g]),
        .a_drv     (a_drv[g]),
        .b_drv     (b_drv[g]),
        .resp      (resp[g]),
        .busy      (busy[g]),
        .done      (done[g]),
        .pass      (pass[g]),
        .err_count (err_count[g]),
        .fail_vec  (fail_vec[g]),
        .fail_gate (fail_gate[g])
      );
      assign resp[g] = drive_resp(a_drv[g], b_drv[g], mode[g], four_state, unk);
    end
  endgenerate

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  // Model: cycles elapsed since the accepted start (-1 = idle after reset).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        n_m[i] <= -1;
      end else if (start[i] && !(n_m[i] >= 0 && n_m[i] < 4 * (sc_of(i) + 1))) begin
        n_m[i] <= 0;
        md[i]  <= mode[i];
      end else if (n_m[i] >= 0 && n_m[i] < 4 * (sc_of(i) + 1)) begin
        n_m[i] <= n_m[i] + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int         s;
    int         len;
    int         n;
    int         k;
    int         vcur;
    int         e;
    logic [3:0] fv;
    logic [6:0] fg;
    logic [6:0] mk;
    bit         bz;
    bit         dn;
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        s   = sc_of(i);
        len = 4 * (s + 1);
        n   = n_m[i];
        if (n < 0) begin
          bz = 0; dn = 0; vcur = 0; k = 0;
        end else if (n < len) begin
          bz = 1; dn = 0; vcur = n / (s + 1); k = vcur;
        end else begin
          bz = 0; dn = 1; vcur = 3; k = 4;
        end
        e = 0; fv = '0; fg = '0;
        for (int v = 0; v < k; v++) begin
          mk = vec_mask(v, md[i]);
          e  = e + $countones(mk);
          if (mk != 7'd0) fv[v] = 1'b1;
          fg = fg | mk;
        end
        if (e > 28) e = 28;
        chk("busy", i, busy[i], bz);
        chk("done", i, done[i], dn);
        chk("pass", i, pass[i], (dn && e == 0) ? 1 : 0);
        chk("err_count", i, err_count[i], e);
        chk("fail_vec", i, fail_vec[i], fv);
        chk("fail_gate", i, fail_gate[i], fg);
        chk("a_drv", i, a_drv[i], (vcur >> 1) & 1);
        chk("b_drv", i, b_drv[i], vcur & 1);
      end
    end
  end

  task automatic run(input int i, input int exp_lat, input int repulse_at);
    int lat;
    lat = -1;
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    chk("busy_at_accept", i, busy[i], 1);
    chk("done_cleared", i, done[i], 0);
    chk("err_cleared", i, err_count[i], 0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start[i] = (c == repulse_at);
      if (done[i]) begin
        lat = c;
        break;
      end
    end
    start[i] = 1'b0;
    chk("latency", i, lat, exp_lat);
  endtask

  initial begin
    bit seen_done;
    checks  = 0;
    errors  = 0;
    cmp_en  = 0;
    n_m     = '{-1, -1};
    md      = '{0, 0};
    mode    = '{0, 0};
    rst     = 2'b11;
    start   = 2'b00;
    unk     = 1'bx;
    four_state = $isunknown(unk);
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("reset_busy", 0, busy[0], 0);
    chk("reset_err", 1, err_count[1], 0);
    rst = 2'b00;

    run(0, 20, 0);
    chk("good_pass", 0, pass[0], 1);
    chk("good_err", 0, err_count[0], 0);
    chk("good_fail_gate", 0, fail_gate[0], 7'b0000000);

    mode[0] = 1;
    run(0, 20, 0);
    chk("and_sa0_err", 0, err_count[0], 1);
    chk("and_sa0_fail_vec", 0, fail_vec[0], 4'b1000);
    chk("and_sa0_fail_gate", 0, fail_gate[0], 7'b0001000);
    chk("and_sa0_pass", 0, pass[0], 0);

    mode[0] = 2;
    run(0, 20, 7);
    chk("swap_err", 0, err_count[0], 8);
    chk("swap_fail_vec", 0, fail_vec[0], 4'b1111);
    chk("swap_fail_gate", 0, fail_gate[0], 7'b0000011);

    mode[0] = 5;
    run(0, 20, 0);
    chk("inv_err_max", 0, err_count[0], 28);
    chk("inv_fail_gate", 0, fail_gate[0], 7'b1111111);

    mode[0] = 2;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_a_drv", 0, a_drv[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_err", 0, err_count[0], 0);
    chk("rst_a_drv", 0, a_drv[0], 0);
    chk("rst_fail_vec", 0, fail_vec[0], 4'b0000);
    seen_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done[0]) seen_done = 1;
    end
    chk("rst_no_done", 0, seen_done, 0);
    mode[0] = 0;
    run(0, 20, 0);
    chk("after_rst_pass", 0, pass[0], 1);

    mode[1] = 3;
    run(1, 8, 0);
    chk("nor_x_err", 1, err_count[1], 4);
    chk("nor_x_fail_gate", 1, fail_gate[1], 7'b0010000);
    chk("nor_x_fail_vec", 1, fail_vec[1], 4'b1111);

    mode[1] = 4;
    run(1, 8, 0);
    chk("or_sa1_err", 1, err_count[1], 1);
    chk("or_sa1_fail_vec", 1, fail_vec[1], 4'b0001);
    chk("or_sa1_fail_gate", 1, fail_gate[1], 7'b0000100);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
